// File: rtl/add_result_buffer.sv
// Credit-managed result FIFO for a pipelined adder: issues are gated so that every
// in-flight result is guaranteed a slot when it completes.
module add_result_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  output logic                    issue_ok,
  input  logic                    res_en,
  input  logic [DATA_WIDTH:0]     res_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH:0]     m_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    err_issue,
  output logic                    err_unexp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0]     cnt_t;
  typedef logic [AW-1:0]     ptr_t;
  typedef logic [DATA_WIDTH:0] word_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  cnt_t  outstanding;
  cnt_t  inflight;
  cnt_t  level_q;
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  word_t mem [DEPTH];

  logic issue_acc;
  logic pop;
  logic wr;

  // Credit check uses only registered state, so a pop frees a credit one cycle later.
  assign issue_ok  = (outstanding < FULL);
  assign m_valid   = (level_q != '0);
  assign m_data    = mem[rd_ptr];
  assign level     = level_q;

  assign issue_acc = i_en && issue_ok;
  assign pop       = m_valid && m_ready;
  // A completion is only stored if it was announced; the full-without-pop guard is
  // unreachable under the credit rule but keeps a stray write from corrupting the head.
  assign wr        = res_en && (inflight != '0) && ((level_q != FULL) || pop);

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      inflight    <= '0;
      level_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err_issue   <= 1'b0;
      err_unexp   <= 1'b0;
    end else begin
      outstanding <= outstanding + cnt_t'(issue_acc) - cnt_t'(pop);
      inflight    <= inflight + cnt_t'(issue_acc) - cnt_t'(wr);
      level_q     <= level_q + cnt_t'(wr) - cnt_t'(pop);
      if (wr)  wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
      if (i_en && !issue_ok)          err_issue <= 1'b1;
      if (res_en && inflight == '0)   err_unexp <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are never
  // observed while level is zero, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[wr_ptr] <= res_data;
  end

endmodule

// File: tb/tb_add_result_buffer.sv
// Self-checking bench for add_result_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the buffer's rules.
module tb_add_result_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_en;
  logic          issue_ok;
  logic          res_en;
  logic [DW:0]   res_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW:0]   m_data;
  logic [3:0]    level;
  logic          err_issue;
  logic          err_unexp;

  add_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .issue_ok  (issue_ok),
    .res_en    (res_en),
    .res_data  (res_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level     (level),
    .err_issue (err_issue),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  // Reference model: results waiting for the consumer, and issues not yet completed.
  logic [DW:0] q[$];
  int          m_inflight = 0;
  bit          m_err_issue = 0;
  bit          m_err_unexp = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".level"},     DW'(level),     DW'(q.size()));
    chk({tag, ".m_valid"},   DW'(m_valid),   DW'(q.size() != 0));
    chk({tag, ".issue_ok"},  DW'(issue_ok),  DW'((m_inflight + q.size()) < DEPTH));
    chk({tag, ".err_issue"}, DW'(err_issue), DW'(m_err_issue));
    chk({tag, ".err_unexp"}, DW'(err_unexp), DW'(m_err_unexp));
    if (q.size() != 0) chk({tag, ".m_data"}, m_data, q[0]);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit can_issue;
    bit do_pop;
    if (rst) begin
      q.delete();
      m_inflight  = 0;
      m_err_issue = 0;
      m_err_unexp = 0;
    end else begin
      can_issue = (m_inflight + q.size()) < DEPTH;
      do_pop    = (q.size() != 0) && m_ready;
      if (i_en && !can_issue) m_err_issue = 1;
      if (do_pop) void'(q.pop_front());
      if (res_en) begin
        if (m_inflight > 0) begin
          q.push_back(res_data);
          m_inflight--;
        end else begin
          m_err_unexp = 1;
        end
      end
      if (i_en && can_issue) m_inflight++;
    end
  endtask

  // One clock: apply inputs, check outputs mid-cycle, update model, take the edge.
  task automatic cyc(input string tag, input logic ie, input logic re,
                     input logic [DW:0] rd, input logic mr, input logic r);
    i_en = ie; res_en = re; res_data = rd; m_ready = mr; rst = r;
    @(negedge clk);
    check_outputs(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW:0] rnd_word();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    i_en = 0; res_en = 0; res_data = '0; m_ready = 0; rst = 1;
    @(posedge clk);
    #1;
    model_edge();

    // Reset state and priority of reset over active inputs.
    cyc("reset", 1, 1, '1, 1, 1);
    cyc("post_reset", 0, 0, '0, 0, 0);

    // Single round trip with a carry-only sum, four-cycle adder latency.
    cyc("single.issue", 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("single.wait", 0, 0, '0, 0, 0);
    cyc("single.res", 0, 1, 65'h1_0000_0000_0000_0000, 0, 0);
    cyc("single.hold", 0, 0, '0, 0, 0);
    cyc("single.pop", 0, 0, '0, 1, 0);
    cyc("single.empty", 0, 0, '0, 0, 0);

    // Unexpected completion with nothing in flight.
    cyc("unexp.res", 0, 1, rnd_word(), 0, 0);
    cyc("unexp.after", 0, 0, '0, 0, 0);
    cyc("unexp.rst", 0, 0, '0, 0, 1);

    // Fill credits with the consumer stalled; the ninth issue is an error.
    for (int i = 0; i < DEPTH; i++) cyc("fill.issue", 1, 0, '0, 0, 0);
    cyc("fill.over", 1, 0, '0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc("fill.res", 0, 1, rnd_word(), 0, 0);
    cyc("fill.stall", 0, 0, '0, 0, 0);
    cyc("fill.stall2", 0, 0, '0, 0, 0);

    // Full buffer with the consumer streaming: issues offered every cycle, results
    // returned right away, so credits recycle one pop behind.
    for (int i = 0; i < 3 * DEPTH; i++) cyc("stream", 1, (m_inflight > 0), rnd_word(), 1, 0);
    for (int i = 0; i < 2 * DEPTH; i++) cyc("stream.drain", 0, (m_inflight > 0), rnd_word(), 1, 0);
    cyc("stream.rst", 0, 0, '0, 0, 1);

    // Walk both pointers to DEPTH-1, then a simultaneous write and pop at level 1.
    for (int i = 0; i < DEPTH - 1; i++) begin
      cyc("wrap.issue", 1, 0, '0, 0, 0);
      cyc("wrap.res", 0, 1, rnd_word(), 0, 0);
      cyc("wrap.pop", 0, 0, '0, 1, 0);
    end
    cyc("wrap.issue2", 1, 0, '0, 0, 0);
    cyc("wrap.issue2b", 1, 0, '0, 0, 0);
    cyc("wrap.res_last", 0, 1, rnd_word(), 0, 0);
    cyc("wrap.res_pop", 0, 1, rnd_word(), 1, 0);
    cyc("wrap.level1", 0, 0, '0, 0, 0);
    cyc("wrap.pop0", 0, 0, '0, 1, 0);
    cyc("wrap.empty", 0, 0, '0, 0, 0);

    // Reset with three stored and two in flight; late completions are unexpected.
    for (int i = 0; i < 5; i++) cyc("midrst.issue", 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("midrst.res", 0, 1, rnd_word(), 0, 0);
    cyc("midrst.pre", 0, 0, '0, 0, 1);
    cyc("midrst.post", 0, 0, '0, 0, 0);
    cyc("midrst.late1", 0, 1, rnd_word(), 0, 0);
    cyc("midrst.late2", 0, 1, rnd_word(), 0, 0);
    cyc("midrst.end", 0, 0, '0, 0, 1);

    // Random traffic; completions mostly follow real issues, with rare strays.
    for (int i = 0; i < 600; i++) begin
      logic ie, re, mr;
      ie = ($urandom_range(0, 3) != 0);
      re = (m_inflight > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      mr = ($urandom_range(0, 2) != 0);
      cyc("rand", ie, re, rnd_word(), mr, ($urandom_range(0, 150) == 0));
    end
    cyc("final", 0, 0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
